// File: rtl/return_stack_pkg.sv
// Shared constants and the request decode for the tiny_cpu return-address stack.
package return_stack_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        OpNone = 2'b00,
        OpPop  = 2'b01,
        OpPush = 2'b10,
        OpBoth = 2'b11
    } op_e;

    function automatic op_e decode_op(input logic push, input logic pop);
        return op_e'({push, pop});
    endfunction

endpackage

// File: rtl/return_stack_mem.sv
// DEPTH x N entry storage: one synchronous write port, one asynchronous read port.
module return_stack_mem #(
    parameter int unsigned N     = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [N-1:0]     i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [N-1:0]     o_rdata
);

    logic [N-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_stack.sv
// Circular LIFO of return addresses; pop_addr/pop_valid feed the program counter load path.
module return_stack
    import return_stack_pkg::*;
#(
    parameter int unsigned N     = ADDR_W,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic [N-1:0]   push_addr,
    input  logic           pop,
    output logic [N-1:0]   pop_addr,
    output logic           pop_valid,
    output logic           empty,
    output logic           full,
    output logic [PTR_W:0] level,
    output logic           overflow,
    output logic           underflow,
    input  logic           clr_err
);

    localparam int unsigned LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] r_tp;
    logic [LVL_W-1:0] r_level;
    logic [N-1:0]     r_pop_addr;
    logic             r_pop_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic [PTR_W-1:0] w_tp_m1;
    logic [N-1:0]     w_top;
    logic             w_empty;
    logic             w_full;
    logic             w_we;
    logic [PTR_W-1:0] w_waddr;
    op_e              w_op;

    assign w_op    = decode_op(push, pop);
    assign w_tp_m1 = r_tp - PTR_W'(1);
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_W'(DEPTH));

    // Push+pop on a non-empty stack replaces the top in place; on empty it only forwards.
    assign w_we    = push && !(pop && w_empty);
    assign w_waddr = pop ? w_tp_m1 : r_tp;

    return_stack_mem #(
        .N     (N),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (push_addr),
        .i_raddr (w_tp_m1),
        .o_rdata (w_top)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tp        <= '0;
            r_level     <= '0;
            r_pop_addr  <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // Cleared first so a same-cycle error below takes precedence.
            if (clr_err) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
            r_pop_valid <= 1'b0;
            case (w_op)
                OpPush: begin
                    r_tp <= r_tp + PTR_W'(1);
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_level <= r_level + LVL_W'(1);
                    end
                end
                OpPop: begin
                    if (w_empty) begin
                        r_underflow <= 1'b1;
                    end else begin
                        r_pop_addr  <= w_top;
                        r_pop_valid <= 1'b1;
                        r_tp        <= w_tp_m1;
                        r_level     <= r_level - LVL_W'(1);
                    end
                end
                OpBoth: begin
                    r_pop_addr  <= w_empty ? push_addr : w_top;
                    r_pop_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign pop_addr  = r_pop_addr;
    assign pop_valid = r_pop_valid;
    assign empty     = w_empty;
    assign full      = w_full;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
